seq_bit_serializer: RTL and testbench

SEQ_BIT_SERIALIZER -- requirements
Module: seq_bit_serializer

---
 rtl/seq_bit_serializer.sv | 93 +++++++++
 tb/tb_seq_bit_serializer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial front end for a sequence detector: one holding word plus one shifting word, MSB first.
// One bit per bit_en slot; words stream gaplessly while the holding register is refilled.
module seq_bit_serializer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  input  logic             bit_en,
  input  logic             clear,
  output logic             x,
  output logic             x_strobe,
  output logic             frame_start,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);

  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             x_q, x_d;
  logic             strobe_q, strobe_d;
  logic             frame_q, frame_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      x_q         <= 1'b0;
      strobe_q    <= 1'b0;
      frame_q     <= 1'b0;
    end else begin
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      x_q         <= x_d;
      strobe_q    <= strobe_d;
      frame_q     <= frame_d;
    end
  end

  always_comb begin
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    x_d         = x_q;
    strobe_d    = 1'b0;
    frame_d     = 1'b0;

    if (clear) begin
      hold_full_d = 1'b0;
      shift_d     = '0;
      bit_cnt_d   = '0;
      x_d         = 1'b0;
    end else begin
      if (bit_en) begin
        if (bit_cnt_q != '0) begin
          x_d       = shift_q[WIDTH-1];
          shift_d   = {shift_q[WIDTH-2:0], 1'b0};
          bit_cnt_d = bit_cnt_q - CNT_W'(1);
          strobe_d  = 1'b1;
        end else if (hold_full_q) begin
          x_d         = hold_q[WIDTH-1];
          shift_d     = {hold_q[WIDTH-2:0], 1'b0};
          bit_cnt_d   = CNT_W'(WIDTH - 1);
          hold_full_d = 1'b0;
          strobe_d    = 1'b1;
          frame_d     = 1'b1;
        end
      end
      // Accept needs hold empty and transfer needs it full, so they never collide.
      if (data_valid && !hold_full_q) begin
        hold_d      = data_in;
        hold_full_d = 1'b1;
      end
    end
  end

  assign data_ready  = ~hold_full_q;
  assign busy        = hold_full_q | (bit_cnt_q != '0);
  assign x           = x_q;
  assign x_strobe    = strobe_q;
  assign frame_start = frame_q;

endmodule

// File: tb/tb_seq_bit_serializer.sv
// Bench for seq_bit_serializer: directed scenarios plus random traffic against a bit-queue reference model.
module tb_seq_bit_serializer;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] data_in;
  logic       data_valid;
  logic       data_ready;
  logic       bit_en;
  logic       clear;
  logic       x;
  logic       x_strobe;
  logic       frame_start;
  logic       busy;

  seq_bit_serializer #(.WIDTH(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .data_in     (data_in),
    .data_valid  (data_valid),
    .data_ready  (data_ready),
    .bit_en      (bit_en),
    .clear       (clear),
    .x           (x),
    .x_strobe    (x_strobe),
    .frame_start (frame_start),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: a held word plus a queue of bits still to leave the shifter.
  bit       m_full;
  bit [7:0] m_hold;
  bit       mq[$];
  bit       m_x, m_str, m_fs;

  // Capture of what the DUT actually emitted.
  logic [31:0] cap;
  int          cap_n, fs_n, cyc, first_s, last_s;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_full = 1'b0;
    mq.delete();
    m_x   = 1'b0;
    m_str = 1'b0;
    m_fs  = 1'b0;
  endtask

  task automatic model_step(input bit v, input bit [7:0] d, input bit be, input bit clr);
    bit acc;
    acc   = v && !m_full && !clr;
    m_str = 1'b0;
    m_fs  = 1'b0;
    if (clr) begin
      m_full = 1'b0;
      mq.delete();
      m_x = 1'b0;
    end else begin
      if (be) begin
        if (mq.size() > 0) begin
          m_x   = mq.pop_front();
          m_str = 1'b1;
        end else if (m_full) begin
          for (int i = 7; i >= 0; i--) mq.push_back(m_hold[i]);
          m_x    = mq.pop_front();
          m_str  = 1'b1;
          m_fs   = 1'b1;
          m_full = 1'b0;
        end
      end
      if (acc) begin
        m_hold = d;
        m_full = 1'b1;
      end
    end
  endtask

  task automatic compare_all();
    chk("x",           x,           m_x);
    chk("x_strobe",    x_strobe,    m_str);
    chk("frame_start", frame_start, m_fs);
    chk("busy",        busy,        m_full || (mq.size() != 0));
    chk("data_ready",  data_ready,  !m_full);
  endtask

  task automatic cap_reset();
    cap = '0; cap_n = 0; fs_n = 0; first_s = -1; last_s = -1;
  endtask

  task automatic cycle(input bit v, input bit [7:0] d, input bit be, input bit clr);
    data_valid = v;
    data_in    = d;
    bit_en     = be;
    clear      = clr;
    @(posedge clk);
    model_step(v, d, be, clr);
    #1;
    compare_all();
    cyc++;
    if (x_strobe === 1'b1) begin
      cap = {cap[30:0], x};
      cap_n++;
      if (first_s < 0) first_s = cyc;
      last_s = cyc;
      if (frame_start === 1'b1) fs_n++;
    end
  endtask

  initial begin
    bit [7:0] wl [2];
    int       k;
    bit       v;

    reset = 1'b0; data_in = '0; data_valid = 1'b0; bit_en = 1'b0; clear = 1'b0;
    cyc = 0;
    model_reset();
    #1;
    compare_all();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    // 8'hAA with bit_en always high, offered on the very first edge after release.
    cap_reset();
    cycle(1'b1, 8'hAA, 1'b1, 1'b0);
    repeat (8) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    chk("aa_bits", cap[7:0], 8'hAA);
    chk("aa_nstrobe", cap_n, 8);
    chk("aa_frames", fs_n, 1);
    chk("aa_busy_after", busy, 1'b0);

    // Back-to-back A0 then 5F, offered continuously until each is taken.
    wl[0] = 8'hA0; wl[1] = 8'h5F; k = 0;
    cap_reset();
    repeat (20) begin
      v = (k < 2);
      if (v && !m_full) begin
        cycle(1'b1, wl[k], 1'b1, 1'b0);
        k++;
      end else begin
        cycle(v, (k < 2) ? wl[k] : 8'h00, 1'b1, 1'b0);
      end
    end
    chk("b2b_bits", cap[15:0], 16'hA05F);
    chk("b2b_nstrobe", cap_n, 16);
    chk("b2b_gapless", last_s - first_s, 15);
    chk("b2b_frames", fs_n, 2);

    // bit_en every third cycle.
    cap_reset();
    cycle(1'b1, 8'hC3, 1'b0, 1'b0);
    for (int i = 0; i < 30; i++) cycle(1'b0, 8'h00, (i % 3) == 0, 1'b0);
    chk("c3_bits", cap[7:0], 8'hC3);
    chk("c3_nstrobe", cap_n, 8);

    // Held word must survive further offers while data_ready is low.
    cap_reset();
    cycle(1'b1, 8'h3C, 1'b0, 1'b0);
    repeat (4) cycle(1'b1, 8'($urandom), 1'b0, 1'b0);
    repeat (9) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    chk("hold_bits", cap[7:0], 8'h3C);
    chk("hold_nstrobe", cap_n, 8);

    // Clear after three bits of F0 with a second word held; same-cycle offer is dropped.
    cap_reset();
    cycle(1'b1, 8'hF0, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    cycle(1'b1, 8'h81, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    chk("clr_pre_bits", cap[2:0], 3'b111);
    cycle(1'b1, 8'h55, 1'b1, 1'b1);
    chk("clr_x", x, 1'b0);
    chk("clr_busy", busy, 1'b0);
    chk("clr_ready", data_ready, 1'b1);
    cap_reset();
    repeat (5) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    chk("clr_no_strobe", cap_n, 0);

    // Asynchronous reset mid-word, between edges.
    cycle(1'b1, 8'hE7, 1'b1, 1'b0);
    repeat (3) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    chk("arst_x", x, 1'b0);
    chk("arst_strobe", x_strobe, 1'b0);
    chk("arst_frame", frame_start, 1'b0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_ready", data_ready, 1'b1);
    @(posedge clk);
    #2;
    reset = 1'b1;
    cap_reset();
    cycle(1'b1, 8'h0A, 1'b1, 1'b0);
    repeat (10) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    chk("post_rst_bits", cap[7:0], 8'h0A);
    chk("post_rst_nstrobe", cap_n, 8);
    chk("post_rst_frames", fs_n, 1);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 1) == 1, 8'($urandom), $urandom_range(0, 3) != 0,
            $urandom_range(0, 63) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
